// File: rtl/binary_down_timer_if.sv
// Load handshake, run controls and status of the binary down-timer.
// The master side issues loads and run controls; the slave side is the timer.
interface binary_down_timer_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             auto_reload;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;

  modport master (
    output load_valid,
    output load_value,
    output enable,
    output auto_reload,
    output abort,
    input  load_ready,
    input  count,
    input  busy,
    input  tc
  );

  modport slave (
    input  load_valid,
    input  load_value,
    input  enable,
    input  auto_reload,
    input  abort,
    output load_ready,
    output count,
    output busy,
    output tc
  );
endinterface

// File: rtl/binary_down_timer.sv
// Loadable binary down-timer with a one-cycle terminal-count pulse and optional auto-reload.
//   state | meaning
//   IDLE  | waiting for a load; load_ready=1, count holds
//   RUN   | counting down on enabled cycles; busy=1
module binary_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  binary_down_timer_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic [WIDTH-1:0] reload_q, reload_nxt;
  logic             tc_q, tc_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      count_q  <= count_nxt;
      reload_q <= reload_nxt;
      tc_q     <= tc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count_q;
    reload_nxt = reload_q;
    tc_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load_valid) begin
          count_nxt  = bus.load_value;
          reload_nxt = bus.load_value;
          // A zero load expires immediately without ever entering RUN.
          if (bus.load_value == '0) begin
            tc_nxt = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          count_nxt = '0;
          state_nxt = IDLE;
        end else if (bus.enable) begin
          if (count_q > WIDTH'(1)) begin
            count_nxt = count_q - WIDTH'(1);
          end else if (bus.auto_reload) begin
            count_nxt = reload_q;
            tc_nxt    = 1'b1;
          end else begin
            // Terminal step lands on zero; count_q is never 0 in RUN, so no wrap.
            count_nxt = '0;
            state_nxt = IDLE;
            tc_nxt    = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  assign bus.count      = count_q;
  assign bus.tc         = tc_q;
  assign bus.busy       = (state == RUN);
  assign bus.load_ready = (state == IDLE);

endmodule

// File: tb/tb_binary_down_timer.sv
// Directed vector bench for binary_down_timer (WIDTH=4).
module tb_binary_down_timer;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  binary_down_timer_if #(.WIDTH(4)) bus ();

  binary_down_timer #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       lv;
    logic [3:0] val;
    logic       en;
    logic       ar;
    logic       ab;
    logic [3:0] ec;
    logic       eb;
    logic       et;
    logic       er;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, logic rst, logic lv, logic [3:0] val, logic en,
                              logic ar, logic ab, logic [3:0] ec, logic eb, logic et, logic er);
    vec_t v;
    v.name = name; v.rst = rst; v.lv = lv; v.val = val; v.en = en; v.ar = ar; v.ab = ab;
    v.ec = ec; v.eb = eb; v.et = et; v.er = er;
    vecs.push_back(v);
  endfunction

  task automatic drive(logic rst, logic lv, logic [3:0] val, logic en, logic ar, logic ab);
    @(negedge clk);
    reset           = rst;
    bus.load_valid  = lv;
    bus.load_value  = val;
    bus.enable      = en;
    bus.auto_reload = ar;
    bus.abort       = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [3:0] ec, logic eb, logic et, logic er);
    n_vec++;
    if (bus.count !== ec || bus.busy !== eb || bus.tc !== et || bus.load_ready !== er) begin
      n_bad++;
      $display("FAIL %s: got count=%0d busy=%b tc=%b ready=%b, want count=%0d busy=%b tc=%b ready=%b",
               name, bus.count, bus.busy, bus.tc, bus.load_ready, ec, eb, et, er);
    end
  endtask

  initial begin
    logic [3:0] seq4[9];
    logic [3:0] cnt;
    logic       en;
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.load_valid = 1'b0; bus.load_value = '0; bus.enable = 1'b0;
    bus.auto_reload = 1'b0; bus.abort = 1'b0;

    //   name          rst lv val  en ar ab  count busy tc ready
    add("reset0",      1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
    add("reset1",      1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
    add("idle_en",     0, 0, 4'd0, 1, 0, 1, 4'd0, 0, 0, 1);
    add("load5",       0, 1, 4'd5, 1, 0, 0, 4'd5, 1, 0, 0);
    add("run4",        0, 0, 4'd5, 1, 0, 0, 4'd4, 1, 0, 0);
    add("run3",        0, 0, 4'd5, 1, 0, 0, 4'd3, 1, 0, 0);
    add("run2",        0, 0, 4'd5, 1, 0, 0, 4'd2, 1, 0, 0);
    add("run1",        0, 0, 4'd5, 1, 0, 0, 4'd1, 1, 0, 0);
    add("tc5",         0, 0, 4'd5, 1, 0, 0, 4'd0, 0, 1, 1);
    add("post_tc5",    0, 0, 4'd5, 1, 0, 0, 4'd0, 0, 0, 1);
    add("load9_en0",   0, 1, 4'd9, 0, 0, 0, 4'd9, 1, 0, 0);
    add("run8",        0, 0, 4'd9, 1, 0, 0, 4'd8, 1, 0, 0);
    add("run7",        0, 0, 4'd9, 1, 0, 0, 4'd7, 1, 0, 0);
    add("run6",        0, 0, 4'd9, 1, 0, 0, 4'd6, 1, 0, 0);
    add("run5",        0, 0, 4'd9, 1, 0, 0, 4'd5, 1, 0, 0);
    add("run4b",       0, 0, 4'd9, 1, 0, 0, 4'd4, 1, 0, 0);
    add("run3b",       0, 0, 4'd9, 1, 0, 0, 4'd3, 1, 0, 0);
    add("load_in_run", 0, 1, 4'd4, 1, 0, 0, 4'd2, 1, 0, 0);
    add("abort",       0, 1, 4'd6, 1, 0, 1, 4'd0, 0, 0, 1);
    add("post_abort",  0, 0, 4'd6, 1, 0, 0, 4'd0, 0, 0, 1);
    add("load0",       0, 1, 4'd0, 1, 0, 0, 4'd0, 0, 1, 1);
    add("post_load0",  0, 0, 4'd0, 1, 0, 0, 4'd0, 0, 0, 1);
    add("load10",      0, 1, 4'd10,1, 0, 0, 4'd10,1, 0, 0);
    add("run9",        0, 0, 4'd10,1, 0, 0, 4'd9, 1, 0, 0);
    add("run8c",       0, 0, 4'd10,1, 0, 0, 4'd8, 1, 0, 0);
    add("run7c",       0, 0, 4'd10,1, 0, 0, 4'd7, 1, 0, 0);
    add("reset_run",   1, 0, 4'd10,1, 0, 0, 4'd0, 0, 0, 1);
    add("after_rst",   0, 0, 4'd10,1, 0, 0, 4'd0, 0, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].lv, vecs[i].val, vecs[i].en, vecs[i].ar, vecs[i].ab);
      check(vecs[i].name, vecs[i].ec, vecs[i].eb, vecs[i].et, vecs[i].er);
    end

    // Load 15 with a 3-cycle enable gap: tc lands 18 cycles after the load edge.
    drive(0, 1, 4'd15, 1, 0, 0);
    check("gap_load15", 4'd15, 1, 0, 0);
    cnt = 4'd15;
    for (int c = 1; c <= 18; c++) begin
      en = !(c >= 5 && c <= 7);
      if (en) cnt = cnt - 4'd1;
      drive(0, 0, 4'd15, en, 0, 0);
      if (c == 18) check("gap_tc", 4'd0, 0, 1, 1);
      else         check("gap_run", cnt, 1, 0, 0);
    end

    // Auto-reload with 3; load_value changes mid-run must not alter the reload value.
    seq4 = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
    drive(0, 1, 4'd3, 1, 1, 0);
    check("ar_load3", 4'd3, 1, 0, 0);
    for (int k = 0; k < 9; k++) begin
      drive(0, 0, 4'd7 + 4'(k), 1, 1, 0);
      check("ar_run", seq4[k], 1, (k % 3 == 2), 0);
    end
    drive(0, 0, 4'd7, 1, 0, 0);
    check("ar_off2", 4'd2, 1, 0, 0);
    drive(0, 0, 4'd7, 1, 0, 0);
    check("ar_off1", 4'd1, 1, 0, 0);
    drive(0, 1, 4'd12, 1, 0, 0);
    check("ar_final_tc", 4'd0, 0, 1, 1);
    drive(0, 1, 4'd4, 1, 0, 0);
    check("reload_after_tc", 4'd4, 1, 0, 0);
    drive(0, 0, 4'd4, 0, 0, 1);
    check("abort_hold_en", 4'd0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, want finish before 200000");
    $fatal(1);
  end
endmodule
